// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared encodings, funct codes, FSM states and datapath width for the EX stage
package ex_mem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/ex_mem_stage_mult_iter.sv
// mult_iter: iterative shift-add multiplier, one iteration per cycle, low DATA_W bits of product
//   start   : load operands a/b and begin (ignored while abort is high)
//   abort   : drop any multiply in progress, clear all state
//   busy    : iterations in progress
//   done    : high during the final iteration; product is valid in that same cycle
//   product : accumulator including the current iteration's partial product
module mult_iter #(
    parameter int DATA_W = 32,
    parameter int CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [DATA_W-1:0] mcand, mplier, acc, acc_nxt;
    logic [CNT_W-1:0]  cnt;

    // Product is taken combinationally so the last iteration and the result
    // register in the EX/MEM stage share the same edge.
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (cnt == CNT_W'(CYCLES - 1));
    assign product = acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (abort) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= done ? '0 : cnt + 1'b1;
            busy   <= !done;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX pipeline stage (ALU, branch adder, dest mux, iterative multiply) feeding the EX/MEM register
//   inputs : in_valid/flush, ID/EX controls (wb_ctl, m_ctl, regdst, alusrc, aluop),
//            ID/EX data (npc, rdata1, rdata2, s_extend, instr_2016, instr_1511)
//   outputs: stall (multiply in progress), EX/MEM register contents
//            (out_valid, wb_ctlout, m_ctlout, add_result, alu_result, zero, rdata2out, muxout)
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [1:0]        wb_ctl,
    input  logic [2:0]        m_ctl,
    input  logic              regdst,
    input  logic              alusrc,
    input  logic [1:0]        aluop,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] s_extend,
    input  logic [4:0]        instr_2016,
    input  logic [4:0]        instr_1511,
    output logic              stall,
    output logic              out_valid,
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic [DATA_W-1:0] add_result,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] rdata2out,
    output logic [4:0]        muxout
);

    state_e            state, state_nxt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] b_op, alu_val, branch;
    logic [4:0]        dest;
    logic              is_mul, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_prod;
    logic [1:0]        c_wb;
    logic [2:0]        c_m;
    logic [DATA_W-1:0] c_add, c_rd2;
    logic [4:0]        c_dest;

    assign funct     = s_extend[5:0];
    assign b_op      = alusrc ? s_extend : rdata2;
    assign dest      = regdst ? instr_1511 : instr_2016;
    assign branch    = npc + (s_extend << 2);
    assign is_mul    = (aluop == ALUOP_FUNCT) && (funct == FUNCT_MULT);
    assign mul_start = (state == IDLE) && in_valid && is_mul && !flush;
    assign stall     = (state == MUL);

    always_comb begin
        alu_val = '0;
        case (aluop)
            ALUOP_ADD: alu_val = rdata1 + b_op;
            ALUOP_SUB: alu_val = rdata1 - b_op;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_val = rdata1 + b_op;
                    FUNCT_SUB: alu_val = rdata1 - b_op;
                    FUNCT_AND: alu_val = rdata1 & b_op;
                    FUNCT_OR:  alu_val = rdata1 | b_op;
                    FUNCT_SLT: alu_val = {{(DATA_W-1){1'b0}}, $signed(rdata1) < $signed(b_op)};
                    default:   alu_val = '0;
                endcase
            end
            default: alu_val = '0;
        endcase
    end

    mult_iter #(
        .DATA_W (DATA_W),
        .CYCLES (MUL_CYCLES)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .abort   (flush),
        .a       (rdata1),
        .b       (b_op),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Leaving MUL on !mul_busy only guards against the multiplier having
    // been cleared underneath the FSM; normally mul_done ends the state.
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = IDLE;
        else if (state == IDLE)
            state_nxt = mul_start ? MUL : IDLE;
        else if (mul_done || !mul_busy)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Controls and pass-through data of a multiply are held here because
    // upstream is free to change its inputs while the stage stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_wb   <= '0;
            c_m    <= '0;
            c_add  <= '0;
            c_rd2  <= '0;
            c_dest <= '0;
        end else if (mul_start) begin
            c_wb   <= wb_ctl;
            c_m    <= m_ctl;
            c_add  <= branch;
            c_rd2  <= rdata2;
            c_dest <= dest;
        end
    end

    // Bubbles clear only valid and the controls; data fields keep their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            wb_ctlout  <= '0;
            m_ctlout   <= '0;
            add_result <= '0;
            alu_result <= '0;
            zero       <= 1'b0;
            rdata2out  <= '0;
            muxout     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            wb_ctlout <= '0;
            m_ctlout  <= '0;
        end else if (state == MUL) begin
            if (mul_done) begin
                out_valid  <= 1'b1;
                wb_ctlout  <= c_wb;
                m_ctlout   <= c_m;
                add_result <= c_add;
                alu_result <= mul_prod;
                zero       <= (mul_prod == '0);
                rdata2out  <= c_rd2;
                muxout     <= c_dest;
            end else begin
                out_valid <= 1'b0;
                wb_ctlout <= '0;
                m_ctlout  <= '0;
            end
        end else if (in_valid && !is_mul) begin
            out_valid  <= 1'b1;
            wb_ctlout  <= wb_ctl;
            m_ctlout   <= m_ctl;
            add_result <= branch;
            alu_result <= alu_val;
            zero       <= (alu_val == '0);
            rdata2out  <= rdata2;
            muxout     <= dest;
        end else begin
            out_valid <= 1'b0;
            wb_ctlout <= '0;
            m_ctlout  <= '0;
        end
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width (only 32 supported).
REQ-002 SHALL have parameter MUL_CYCLES, default 32, multiply iterations.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream ID/EX contents valid this cycle.
REQ-006 flush  input  1  discard the instruction in EX this cycle.
REQ-007 wb_ctl  input  2  write-back control from ID/EX.
REQ-008 m_ctl  input  3  memory control from ID/EX.
REQ-009 regdst, alusrc  input  1 each  EX control from ID/EX.
REQ-010 aluop  input  2  ALU op class from ID/EX.
REQ-011 npc, rdata1, rdata2, s_extend  input  32 each  ID/EX data.
REQ-012 instr_2016, instr_1511  input  5 each  rt and rd fields.
REQ-013 stall  output  1  upstream must hold ID/EX contents stable.
REQ-014 out_valid  output  1  EX/MEM contents valid.
REQ-015 wb_ctlout  output  2; m_ctlout  output  3  registered controls.
REQ-016 add_result  output  32  branch target; alu_result  output  32; zero  output  1.
REQ-017 rdata2out  output  32  store data; muxout  output  5  destination register.

Function
REQ-018 Branch target SHALL be npc + (s_extend << 2), mod 2^32.
REQ-019 B operand SHALL be s_extend when alusrc=1, else rdata2; muxout SHALL be instr_1511 when regdst=1, else instr_2016.
REQ-020 aluop 00 SHALL add; 01 SHALL subtract (A-B); 10 SHALL decode s_extend[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 1 or 0), 0x18 multiply (low 32 bits); other funct or aluop 11 SHALL give result 0.
REQ-021 All arithmetic SHALL wrap mod 2^32; no overflow flag; zero SHALL be 1 exactly when alu_result==0.
REQ-022 Single-cycle ops: with in_valid=1 in IDLE, all outputs SHALL be registered on the next edge with out_valid=1 (latency 1).
REQ-023 in_valid=0 in IDLE SHALL register a bubble: out_valid=0, wb_ctlout=0, m_ctlout=0; data outputs hold their previous values.
REQ-024 FSM states IDLE and MUL; IDLE->MUL when in_valid=1, multiply decoded, flush=0; operands captured on that edge; EX/MEM register receives a bubble on that edge.
REQ-025 In MUL, stall SHALL be 1 (stall is decoded from state, 0 in IDLE); one shift-add iteration per cycle; inputs ignored.
REQ-026 MUL SHALL last exactly MUL_CYCLES cycles; on the last edge, the product and captured controls SHALL be registered with out_valid=1 and the FSM SHALL return to IDLE.
REQ-027 While in MUL, every edge except the last SHALL register a bubble (no duplicated writes downstream).
REQ-028 Back-to-back: the instruction presented in the cycle after MUL exits SHALL be accepted normally, including a further multiply.
REQ-029 flush=1 SHALL take priority over everything: next edge registers a bubble, FSM->IDLE, iteration counter cleared, partial product discarded.
REQ-030 flush and MUL completion on the same edge: flush wins, no valid output.

Reset
REQ-031 rst_n=0 SHALL immediately clear all outputs to 0, FSM to IDLE, counter and multiplier registers to 0; stall=0.
REQ-032 Reset asserted mid-multiply SHALL abort it; after release, no result from the aborted multiply is ever produced.

Structure
REQ-033 Shared package SHALL hold aluop encodings, funct constants (ADD, SUB, AND, OR, SLT, MULT), FSM state enum, DATA_W.
REQ-034 Iterative multiplier SHALL be one sub-module, mult_iter (start, operands, busy, done, product); ALU, mux and EX/MEM register SHALL stay in ex_mem_stage.

Verification
REQ-035 aluop=10, funct 0x22, rdata1=5, rdata2=5, alusrc=0 -> next edge alu_result=0, zero=1, out_valid=1.
REQ-036 aluop=10, funct 0x2A, rdata1=0xFFFFFFFF, rdata2=1 -> alu_result=1 (signed compare).
REQ-037 npc=0x100, s_extend=0xFFFFFFFF -> add_result=0xFC.
REQ-038 multiply 0x0001_0000 x 0x0001_0003 -> stall=1 for exactly 32 cycles, single out_valid pulse, alu_result=0x0003_0000, wb_ctlout equal to captured value.
REQ-039 multiply, flush at iteration 10 -> next edge stall=0, out_valid=0, no later result; following add 2+3 -> alu_result=5.
REQ-040 rst_n low during iteration 5 -> outputs 0 immediately; after release with in_valid=0, out_valid stays 0 for 40 cycles.
